// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response bundle between the execute stage and the
// iterative multiply/divide unit.
//   start/op/a/b/rd_in/kill : request side, driven by the issuing stage
//   busy/done/result/rd_out : response side, driven by the unit
// The master modport is the issuer; the slave modport is the unit.
interface mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd_in;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, op, a, b, rd_in, kill,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, op, a, b, rd_in, kill,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit, one radix-2 step per cycle.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mdu_iter_if slave modport (start/op/a/b/rd_in/kill in,
//          busy/done/result/rd_out out)
// Multiplies run shift-add on operand magnitudes, divides run restoring
// division on magnitudes; signs are applied once at the final step.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  mdu_iter_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
  localparam logic [CW-1:0]   CNT_LAST = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_hi;      // mul: running high half / div: partial remainder
  logic [XLEN-1:0] r_lo;      // mul: multiplier shifting out / div: dividend -> quotient
  logic [XLEN-1:0] r_m;       // mul: |multiplicand| / div: |divisor|
  logic            r_neg;     // product or quotient must be negated
  logic            r_neg_rem; // remainder must be negated
  logic [XLEN-1:0] r_result;

  logic            w_a_sgn;
  logic            w_b_sgn;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_accept;
  logic            w_div_zero;
  logic            w_special;
  logic [XLEN-1:0] w_spec_val;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_shl;
  logic [XLEN:0]   w_div_dif;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;
  logic [2*XLEN-1:0] w_prod_c;
  logic [XLEN-1:0] w_quo_c;
  logic [XLEN-1:0] w_rem_c;
  logic [XLEN-1:0] w_fin;

  // Request decode: operand signedness, magnitudes and early-exit detection.
  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    case (bus.op)
      3'b001, 3'b100, 3'b110: begin
        w_a_sgn = bus.a[XLEN-1];
        w_b_sgn = bus.b[XLEN-1];
      end
      3'b010: begin
        w_a_sgn = bus.a[XLEN-1];
        w_b_sgn = 1'b0;
      end
      default: begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
      end
    endcase
    w_abs_a    = w_a_sgn ? (~bus.a + {{(XLEN-1){1'b0}}, 1'b1}) : bus.a;
    w_abs_b    = w_b_sgn ? (~bus.b + {{(XLEN-1){1'b0}}, 1'b1}) : bus.b;
    w_accept   = (r_state == S_IDLE) && bus.start && !bus.kill;
    w_div_zero = bus.op[2] && (bus.b == {XLEN{1'b0}});
    // Signed overflow only exists for DIV/REM (op[0]==0 among divides).
    w_special  = w_div_zero ||
                 (bus.op[2] && !bus.op[0] && (bus.a == MIN_NEG) && (bus.b == ALL_ONE));
    if (w_div_zero) begin
      w_spec_val = bus.op[1] ? bus.a : ALL_ONE;
    end else begin
      w_spec_val = bus.op[1] ? {XLEN{1'b0}} : MIN_NEG;
    end
  end

  // One iteration step plus sign correction of the would-be final value.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
    w_div_shl = {r_hi, r_lo[XLEN-1]};
    w_div_dif = w_div_shl - {1'b0, r_m};
    if (r_op[2]) begin
      // A borrow out of the trial subtract means the divisor did not fit.
      if (w_div_dif[XLEN]) begin
        w_hi_nxt = w_div_shl[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end else begin
        w_hi_nxt = w_div_dif[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end
    end else begin
      w_hi_nxt = w_mul_sum[XLEN:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
    w_prod_c = r_neg ? (~{w_hi_nxt, w_lo_nxt} + {{(2*XLEN-1){1'b0}}, 1'b1})
                     : {w_hi_nxt, w_lo_nxt};
    w_quo_c  = r_neg ? (~w_lo_nxt + {{(XLEN-1){1'b0}}, 1'b1}) : w_lo_nxt;
    w_rem_c  = r_neg_rem ? (~w_hi_nxt + {{(XLEN-1){1'b0}}, 1'b1}) : w_hi_nxt;
    case (r_op)
      3'b000:         w_fin = w_prod_c[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         w_fin = w_prod_c[2*XLEN-1:XLEN];
      3'b100, 3'b101: w_fin = w_quo_c;
      default:        w_fin = w_rem_c;
    endcase
  end

  // Next-state logic; kill aborts CALC/DONE and masks start in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.kill) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, iteration registers and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= {CW{1'b0}};
      r_op      <= 3'b000;
      r_rd      <= 5'd0;
      r_hi      <= {XLEN{1'b0}};
      r_lo      <= {XLEN{1'b0}};
      r_m       <= {XLEN{1'b0}};
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= bus.op;
            r_rd      <= bus.rd_in;
            r_cnt     <= {CW{1'b0}};
            r_hi      <= {XLEN{1'b0}};
            r_lo      <= bus.op[2] ? w_abs_a : w_abs_b;
            r_m       <= bus.op[2] ? w_abs_b : w_abs_a;
            r_neg     <= w_a_sgn ^ w_b_sgn;
            r_neg_rem <= w_a_sgn;
            if (w_special) begin
              r_result <= w_spec_val;
            end
          end
        end
        S_CALC: begin
          if (!bus.kill) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (r_cnt == CNT_LAST) begin
              r_result <= w_fin;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
  assign bus.rd_out = r_rd;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter.
// Inputs are driven and outputs sampled on the falling clock edge, so a
// request set up in cycle t is sampled by the rising edge that ends cycle t.
module tb_mdu_iter;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_miscmp;

  mdu_iter_if bus ();

  mdu_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request in the current cycle and follow it to its done pulse,
  // checking busy on every cycle, the latency, result, rd_out and the return
  // to IDLE. Returns at the falling edge of cycle t+lat+1.
  task automatic run_op(input string tag, input logic [2:0] op_i,
                        input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic [4:0] rd_i, input logic [31:0] exp_r,
                        input int exp_lat);
    int n;
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    bus.rd_in = rd_i;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n < 40) begin
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, "_res"}, bus.result, exp_r);
    chk({tag, "_rd"}, {27'd0, bus.rd_out}, {27'd0, rd_i});
    @(negedge clk);
    chk({tag, "_done_off"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // Run idle cycles and check that no done pulse appears.
  task automatic quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    int n;
    n_vec     = 0;
    n_miscmp  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.rd_in = 5'd0;
    bus.kill  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_res", bus.result, 32'd0);
    chk("rst_rd", {27'd0, bus.rd_out}, 32'd0);

    // MUL 7 * -3
    run_op("mul_neg", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);

    // Reset mid-operation wins
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.a     = 32'd7;
    bus.b     = 32'hFFFF_FFFD;
    bus.rd_in = 5'd6;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mrst_done", {31'd0, bus.done}, 32'd0);
    chk("mrst_res", bus.result, 32'd0);
    chk("mrst_rd", {27'd0, bus.rd_out}, 32'd0);
    quiet("mrst_no_done", 30);

    // High-half products
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33);
    run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33);
    run_op("mulhsu_2", 3'b010, 32'd2, 32'h8000_0000, 5'd4, 32'h0000_0001, 33);

    // Division signs
    run_op("div_n7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
    run_op("rem_n7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
    run_op("div_7_n2", 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD, 33);
    run_op("rem_7_n2", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'h0000_0001, 33);
    run_op("divu", 3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 33);
    run_op("remu", 3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 33);

    // Special cases
    run_op("div_by0", 3'b100, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", 3'b111, 32'd5, 32'd0, 5'd14, 32'd5, 1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);
    run_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 33);

    // Handshake: starts while busy are ignored
    bus.start = 1'b1;
    bus.op    = 3'b101;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.rd_in = 5'd18;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    bus.rd_in = 5'd19;
    n = 1;
    while (bus.done !== 1'b1 && n < 40) begin
      bus.start = (n == 5);
      @(negedge clk);
      n++;
    end
    bus.start = 1'b1;
    chk("hs_lat", n, 33);
    chk("hs_res", bus.result, 32'd14);
    chk("hs_rd", {27'd0, bus.rd_out}, 32'd18);
    @(negedge clk);
    bus.start = 1'b0;
    chk("hs_ign_done", {31'd0, bus.busy}, 32'd0);
    run_op("hs_next", 3'b101, 32'd9, 32'd3, 5'd19, 32'd3, 33);

    // kill during CALC
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    bus.rd_in = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i < 20; i++) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    chk("kill_busy", {31'd0, bus.busy}, 32'd0);
    chk("kill_done", {31'd0, bus.done}, 32'd0);
    chk("kill_res", bus.result, 32'd3);
    chk("kill_rd", {27'd0, bus.rd_out}, 32'd20);
    quiet("kill_no_done", 20);
    chk("kill_res_hold", bus.result, 32'd3);

    // kill with start in IDLE drops the request
    bus.start = 1'b1;
    bus.kill  = 1'b1;
    bus.op    = 3'b100;
    bus.a     = 32'd5;
    bus.b     = 32'd0;
    bus.rd_in = 5'd21;
    @(negedge clk);
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    chk("ks_busy", {31'd0, bus.busy}, 32'd0);
    quiet("ks_no_done", 5);
    chk("ks_res", bus.result, 32'd3);
    chk("ks_rd", {27'd0, bus.rd_out}, 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit for the multi-cycle execute path.
- Consumes the two register-file read operands (rs1/rs2 data) plus funct3 and the destination register index.
- Produces a 32-bit result and destination index for the write-back mux, which drives the register-file write port.
- One radix-2 step per cycle; divide-by-zero and signed overflow finish early.

Parameters:
XLEN  32  operand/result width; the design is verified only at 32

Ports:
clk     in   1     clock, rising edge
rst     in   1     reset, synchronous, active-high
start   in   1     request; accepted only in IDLE
op      in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a       in   XLEN  rs1 operand (dividend / multiplicand)
b       in   XLEN  rs2 operand (divisor / multiplier)
rd_in   in   5     destination register index
kill    in   1     abort the in-flight operation (pipeline flush)
busy    out  1     high in CALC and DONE
done    out  1     one-cycle pulse; result and rd_out valid
result  out  XLEN  result, held until the next accepted start
rd_out  out  5     captured rd_in, held with result

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, result=0, rd_out=0; counter, accumulators and captured operands cleared. Reset wins over every other input, including mid-operation.
- States: IDLE, CALC, DONE.
- IDLE: start=1 captures op, a, b and rd_in.
  - Special case (divide op with b=0, or DIV/REM with a=0x80000000 and b=0xFFFFFFFF): go to DONE; result loaded with the special value at that edge.
  - Otherwise: go to CALC, cnt=0.
  - start=0: stay in IDLE.
- CALC: one iteration per cycle; cnt increments 0..31. At the edge where cnt=31, write the sign-corrected result and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE; the next start is accepted in the following IDLE cycle.
- Latency:
  - start high in cycle t: normal op has done=1 in cycle t+33; special case has done=1 in cycle t+1.
  - Back-to-back issue: the earliest next start is cycle t+34.
- start while busy=1 is ignored; the captured operands are unchanged.
- kill:
  - In CALC or DONE: go to IDLE at the next edge. No done pulse (a kill sampled in DONE still suppresses nothing already output; done in that cycle stands). result and rd_out keep their prior values.
  - In IDLE: has priority over start; the request is dropped.
- Multiply: form a 64-bit product.
  - MUL: low 32 bits.
  - MULH: high 32 bits, signed×signed.
  - MULHSU: high 32 bits, signed a × unsigned b.
  - MULHU: high 32 bits, unsigned×unsigned.
  - Implementation: magnitude shift-add over 32 steps, then two's-complement negate of the 64-bit product when the operand signs differ.
- Divide: restoring division on magnitudes, 32 steps.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder takes the sign of a.
  - DIVU/REMU use raw unsigned operands.
- Special values:
  - b=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - Overflow: DIV → 0x80000000; REM → 0.
  - Multiply has no special case; multiply by 0 runs the full 33-cycle latency.
- result is registered and changes only on the transition into DONE. rd_out is updated at start acceptance.

Test Plan:
1. Reset: after reset, start MUL a=7 b=0xFFFFFFFD in cycle t → busy=1 from t+1 through t+33; done=1 only in t+33 with result=0xFFFFFFEB and rd_out=rd_in. Repeat with rst=1 asserted in cycle t+10 → next cycle busy=0, done=0, result=0, rd_out=0; done never fires.
2. High-half products at latency 33:
   - MULH 0x80000000×0x80000000 → 0x40000000
   - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE
   - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF
   - MULHSU a=2, b=0x80000000 → 0x00000001
3. Division signs:
   - DIV −7/2 → 0xFFFFFFFD; REM −7%2 → 0xFFFFFFFF
   - DIV 7/−2 → 0xFFFFFFFD; REM → 0x00000001
   - DIVU 100/7 → 14; REMU → 2
4. Special cases, all with done in cycle t+1:
   - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0
   - DIVU 0x80000000/0xFFFFFFFF → 0 at full latency t+33, since unsigned ops have no overflow case
5. Handshake: start DIVU 100/7 in cycle t, then start DIVU 9/3 with a new rd in cycles t+5 and t+33 → only the first completes (done at t+33, result=14, rd_out = first rd). A start in t+34 is accepted; done at t+67 with result=3.
6. kill: kill=1 in cycle t+20 of a MUL → IDLE and busy=0 at t+21; no done; result unchanged. kill and start together in IDLE → request dropped, busy stays 0.
